// File: rtl/vga_pkg.sv
// Shared colours and playfield mode codes for the snake VGA background stage.
package vga_pkg;

    localparam logic [11:0] BORDER_COLOR = 12'hfff;
    localparam logic [11:0] FIELD_COLOR  = 12'h000;
    localparam logic [11:0] GRID_COLOR   = 12'h333;
    localparam logic [11:0] CHECK_COLOR  = 12'h121;
    localparam logic [11:0] BLANK_COLOR  = 12'h000;

    localparam logic [1:0] MODE_SOLID   = 2'd0;
    localparam logic [1:0] MODE_GRID    = 2'd1;
    localparam logic [1:0] MODE_CHECKER = 2'd2;
    localparam logic [1:0] MODE_BORDER  = 2'd3;

endpackage

// File: rtl/vga_cell_counter.sv
// Tracks the pixel offset inside a board cell and the cell index along one axis.
// The index saturates at its maximum so wide rasters never alias back to cell 0.
module vga_cell_counter #(
    parameter int CNT_W     = 16,
    parameter int CELL_SIZE = 32,
    parameter int IDX_W     = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             adv,
    output logic [CNT_W-1:0] off,
    output logic [IDX_W-1:0] idx
);

    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(CELL_SIZE - 1);
    localparam logic [IDX_W-1:0] IDX_MAX  = '1;

    always_ff @(posedge clk) begin
        if (rst) begin
            off <= '0;
            idx <= '0;
        end else if (adv) begin
            if (clr) begin
                off <= '0;
                idx <= '0;
            end else if (off == OFF_LAST) begin
                off <= '0;
                if (idx != IDX_MAX) begin
                    idx <= idx + 1'b1;
                end
            end else begin
                off <= off + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_board_background.sv
// Background stage of the snake VGA pipeline: frame, playfield pattern and cell indices,
// with every output registered two clocks behind its inputs.
module vga_board_background
    import vga_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int H_ACTIVE  = 1024,
    parameter int V_ACTIVE  = 768,
    parameter int CELL_SIZE = 32,
    parameter int IDX_W     = 6,
    parameter int BORDER_W  = 4,
    parameter int GRID_W    = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] hcount_in,
    input  logic [CNT_W-1:0] vcount_in,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic             hblnk_in,
    input  logic             vblnk_in,
    input  logic [1:0]       mode_in,
    output logic [CNT_W-1:0] hcount_out,
    output logic [CNT_W-1:0] vcount_out,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic             hblnk_out,
    output logic             vblnk_out,
    output logic [11:0]      rgb_out,
    output logic [IDX_W-1:0] cell_col_out,
    output logic [IDX_W-1:0] cell_row_out,
    output logic             in_board_out
);

    localparam logic [CNT_W-1:0] H_ACT     = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT     = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] BORD      = CNT_W'(BORDER_W);
    localparam logic [CNT_W-1:0] H_BORD_HI = CNT_W'(H_ACTIVE - BORDER_W);
    localparam logic [CNT_W-1:0] V_BORD_HI = CNT_W'(V_ACTIVE - BORDER_W);
    localparam logic [CNT_W-1:0] GRID_LIM  = CNT_W'(GRID_W);

    logic             line_start;
    logic             frame_start;
    logic [CNT_W-1:0] h_q, v_q;
    logic             hs_q, vs_q, hb_q, vb_q;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] x_off, y_off;
    logic [IDX_W-1:0] col, row;
    logic [11:0]      rgb_next;
    logic             in_board_next;
    logic             blank, border;

    assign line_start  = (hcount_in == '0);
    assign frame_start = line_start && (vcount_in == '0);

    vga_cell_counter #(
        .CNT_W     (CNT_W),
        .CELL_SIZE (CELL_SIZE),
        .IDX_W     (IDX_W)
    ) u_h_counter (
        .clk (clk),
        .rst (rst),
        .clr (line_start),
        .adv (1'b1),
        .off (x_off),
        .idx (col)
    );

    vga_cell_counter #(
        .CNT_W     (CNT_W),
        .CELL_SIZE (CELL_SIZE),
        .IDX_W     (IDX_W)
    ) u_v_counter (
        .clk (clk),
        .rst (rst),
        .clr (vcount_in == '0),
        .adv (line_start),
        .off (y_off),
        .idx (row)
    );

    // Mode is latched only at the frame origin so a frame never mixes two patterns.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_q    <= '0;
            v_q    <= '0;
            hs_q   <= 1'b0;
            vs_q   <= 1'b0;
            hb_q   <= 1'b0;
            vb_q   <= 1'b0;
            mode_q <= MODE_SOLID;
        end else begin
            h_q  <= hcount_in;
            v_q  <= vcount_in;
            hs_q <= hsync_in;
            vs_q <= vsync_in;
            hb_q <= hblnk_in;
            vb_q <= vblnk_in;
            if (frame_start) begin
                mode_q <= mode_in;
            end
        end
    end

    always_comb begin
        rgb_next      = BLANK_COLOR;
        in_board_next = 1'b0;
        blank  = hb_q || vb_q || (h_q >= H_ACT) || (v_q >= V_ACT);
        border = (h_q < BORD) || (h_q >= H_BORD_HI) || (v_q < BORD) || (v_q >= V_BORD_HI);
        if (blank) begin
            rgb_next = BLANK_COLOR;
        end else if (border) begin
            rgb_next = BORDER_COLOR;
        end else begin
            in_board_next = 1'b1;
            case (mode_q)
                MODE_SOLID:   rgb_next = FIELD_COLOR;
                MODE_GRID:    rgb_next = ((x_off < GRID_LIM) || (y_off < GRID_LIM)) ? GRID_COLOR : FIELD_COLOR;
                MODE_CHECKER: rgb_next = (col[0] ^ row[0]) ? CHECK_COLOR : FIELD_COLOR;
                default:      rgb_next = BLANK_COLOR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_out   <= '0;
            vcount_out   <= '0;
            hsync_out    <= 1'b0;
            vsync_out    <= 1'b0;
            hblnk_out    <= 1'b0;
            vblnk_out    <= 1'b0;
            rgb_out      <= '0;
            cell_col_out <= '0;
            cell_row_out <= '0;
            in_board_out <= 1'b0;
        end else begin
            hcount_out   <= h_q;
            vcount_out   <= v_q;
            hsync_out    <= hs_q;
            vsync_out    <= vs_q;
            hblnk_out    <= hb_q;
            vblnk_out    <= vb_q;
            rgb_out      <= rgb_next;
            cell_col_out <= col;
            cell_row_out <= row;
            in_board_out <= in_board_next;
        end
    end

endmodule

// File: tb/tb_vga_board_background.sv
// Directed bench for vga_board_background: vector table walked from the frame origin,
// plus reset, mode-change and sync-latency sequences.
module tb_vga_board_background;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] hcount_in, vcount_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [1:0]  mode_in;
    logic [15:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;
    logic [5:0]  cell_col_out, cell_row_out;
    logic        in_board_out;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  mode;
        int          h;
        int          v;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
        logic        inb;
        int          col;
        int          row;
    } vec_t;

    vec_t vecs[20];

    always #5 clk = ~clk;

    vga_board_background dut (
        .clk          (clk),
        .rst          (rst),
        .hcount_in    (hcount_in),
        .vcount_in    (vcount_in),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .hblnk_in     (hblnk_in),
        .vblnk_in     (vblnk_in),
        .mode_in      (mode_in),
        .hcount_out   (hcount_out),
        .vcount_out   (vcount_out),
        .hsync_out    (hsync_out),
        .vsync_out    (vsync_out),
        .hblnk_out    (hblnk_out),
        .vblnk_out    (vblnk_out),
        .rgb_out      (rgb_out),
        .cell_col_out (cell_col_out),
        .cell_row_out (cell_row_out),
        .in_board_out (in_board_out)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int h, input int v, input logic hb, input logic vb,
                         input logic hs, input logic vs);
        @(negedge clk);
        hcount_in = 16'(h);
        vcount_in = 16'(v);
        hblnk_in  = hb;
        vblnk_in  = vb;
        hsync_in  = hs;
        vsync_in  = vs;
    endtask

    // Frame origin, one h=0 cycle per line down to v, then along line v up to h-1.
    task automatic walkTo(input int h, input int v);
        drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int y = 1; y <= v; y++) drive(0, y, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int x = 1; x < h; x++) drive(x, v, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " hcount"}, 32'(hcount_out), 32'd0);
        checkOutput({tag, " vcount"}, 32'(vcount_out), 32'd0);
        checkOutput({tag, " syncs/blanks"}, 32'({hsync_out, vsync_out, hblnk_out, vblnk_out}), 32'd0);
        checkOutput({tag, " rgb"}, 32'(rgb_out), 32'd0);
        checkOutput({tag, " cells"}, 32'({cell_col_out, cell_row_out}), 32'd0);
        checkOutput({tag, " in_board"}, 32'(in_board_out), 32'd0);
    endtask

    task automatic applyStimulus(input int i);
        vec_t t;
        string n;
        t = vecs[i];
        n = $sformatf("vec%0d(m%0d h%0d v%0d)", i, t.mode, t.h, t.v);
        mode_in = t.mode;
        walkTo(t.h, t.v);
        drive(t.h, t.v, t.hb, t.vb, 1'b0, 1'b0);
        drive(t.h + 1, t.v, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput({n, " rgb"}, 32'(rgb_out), 32'(t.rgb));
        checkOutput({n, " in_board"}, 32'(in_board_out), 32'(t.inb));
        checkOutput({n, " col"}, 32'(cell_col_out), 32'(t.col));
        checkOutput({n, " row"}, 32'(cell_row_out), 32'(t.row));
        checkOutput({n, " hcount"}, 32'(hcount_out), 32'(t.h));
        checkOutput({n, " vcount"}, 32'(vcount_out), 32'(t.v));
        checkOutput({n, " blanks"}, 32'({hblnk_out, vblnk_out}), 32'({t.hb, t.vb}));
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        //          mode   h     v    hb    vb    rgb      inb   col row
        vecs[0]  = '{2'd0, 100,  100, 1'b0, 1'b0, 12'h000, 1'b1, 3,  3};
        vecs[1]  = '{2'd1, 64,   70,  1'b0, 1'b0, 12'h333, 1'b1, 2,  2};
        vecs[2]  = '{2'd1, 65,   70,  1'b0, 1'b0, 12'h000, 1'b1, 2,  2};
        vecs[3]  = '{2'd1, 2,    300, 1'b0, 1'b0, 12'hfff, 1'b0, 0,  9};
        vecs[4]  = '{2'd1, 100,  64,  1'b0, 1'b0, 12'h333, 1'b1, 3,  2};
        vecs[5]  = '{2'd2, 10,   10,  1'b0, 1'b0, 12'h000, 1'b1, 0,  0};
        vecs[6]  = '{2'd2, 40,   10,  1'b0, 1'b0, 12'h121, 1'b1, 1,  0};
        vecs[7]  = '{2'd2, 40,   40,  1'b0, 1'b0, 12'h000, 1'b1, 1,  1};
        vecs[8]  = '{2'd2, 100,  70,  1'b0, 1'b0, 12'h121, 1'b1, 3,  2};
        vecs[9]  = '{2'd3, 100,  100, 1'b0, 1'b0, 12'h000, 1'b1, 3,  3};
        vecs[10] = '{2'd3, 64,   70,  1'b0, 1'b0, 12'h000, 1'b1, 2,  2};
        vecs[11] = '{2'd0, 1021, 100, 1'b0, 1'b0, 12'hfff, 1'b0, 31, 3};
        vecs[12] = '{2'd1, 500,  70,  1'b1, 1'b0, 12'h000, 1'b0, 15, 2};
        vecs[13] = '{2'd2, 1023, 100, 1'b0, 1'b0, 12'hfff, 1'b0, 31, 3};
        vecs[14] = '{2'd0, 1030, 100, 1'b0, 1'b0, 12'h000, 1'b0, 32, 3};
        vecs[15] = '{2'd1, 100,  10,  1'b0, 1'b1, 12'h000, 1'b0, 3,  0};
        vecs[16] = '{2'd0, 2100, 10,  1'b0, 1'b0, 12'h000, 1'b0, 63, 0};
        vecs[17] = '{2'd2, 100,  765, 1'b0, 1'b0, 12'hfff, 1'b0, 3,  23};
        vecs[18] = '{2'd1, 100,  770, 1'b0, 1'b0, 12'h000, 1'b0, 3,  24};
        vecs[19] = '{2'd1, 1019, 64,  1'b0, 1'b0, 12'h333, 1'b1, 31, 2};

        rst = 1'b1;
        hcount_in = '0; vcount_in = '0;
        hsync_in = 1'b0; vsync_in = 1'b0; hblnk_in = 1'b0; vblnk_in = 1'b0;
        mode_in = 2'd0;
        repeat (3) @(negedge clk);
        checkAllZero("power-on reset");
        rst = 1'b0;

        for (int i = 0; i < 20; i++) applyStimulus(i);

        // Mode request mid-frame must not alter the current frame.
        mode_in = 2'd0;
        drive(0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int y = 1; y < 200; y++) drive(0, y, 1'b0, 1'b0, 1'b0, 1'b0);
        mode_in = 2'd1;
        for (int x = 0; x <= 65; x++) drive(x, 200, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("mode change same frame rgb", 32'(rgb_out), 32'h000);
        walkTo(64, 200);
        drive(64, 200, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(65, 200, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("mode change next frame rgb", 32'(rgb_out), 32'h333);

        // Sync pulse on pixel 5 must appear exactly two clocks later.
        walkTo(5, 0);
        drive(5, 0, 1'b0, 1'b0, 1'b1, 1'b1);
        drive(6, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("sync delay 1", 32'({hsync_out, vsync_out}), 32'b00);
        drive(7, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("sync delay 2", 32'({hsync_out, vsync_out}), 32'b11);
        drive(8, 0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("sync delay 3", 32'({hsync_out, vsync_out}), 32'b00);

        // Reset in the middle of a line, held for three clocks.
        mode_in = 2'd0;
        walkTo(300, 100);
        drive(300, 100, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(301, 100, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(302, 100, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("pre-reset hcount", 32'(hcount_out), 32'd300);
        rst = 1'b1;
        @(negedge clk);
        checkAllZero("mid-line reset");
        repeat (2) @(negedge clk);
        checkAllZero("reset held");
        rst = 1'b0;
        drive(2, 9, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(3, 9, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("post-reset hcount", 32'(hcount_out), 32'd2);
        checkOutput("post-reset vcount", 32'(vcount_out), 32'd9);
        checkOutput("post-reset rgb", 32'(rgb_out), 32'hfff);
        checkOutput("post-reset in_board", 32'(in_board_out), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
